// File: rtl/alu_pkg.sv
// Shared opcode encoding and datapath width for the execute-stage ALU.
// Imported by the RTL and the testbench.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_NOT = 3'b011,
    OP_SUB = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_XOR = 3'b111
  } opcode_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor used for ADD, SUB and SLT.
// Subtract is A + ~B + 1; the overflow output is the signed overflow.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry,
  output logic              o_ovf
);

  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_full;

  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b}
                + {{DATA_W{1'b0}}, i_sub};

  assign o_sum   = w_full[DATA_W-1:0];
  assign o_carry = w_full[DATA_W];
  assign o_ovf   = (i_a[DATA_W-1] == w_b[DATA_W-1])
                && (o_sum[DATA_W-1] != i_a[DATA_W-1]);

endmodule

// File: rtl/alu_core.sv
// Registered 8-bit ALU for the execute stage, one op per cycle.
// Optional signed-overflow flag output enabled by ALU_OVF_EN.
module alu_core
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic [2:0]        opcode_i,
  output logic [DATA_W-1:0] alu_result_o,
  output logic              set_o,
  output logic              zero
`ifdef ALU_OVF_EN
  ,
  output logic              ovf_o
`endif
);

  opcode_e           w_op;
  logic              w_sub;
  logic [DATA_W-1:0] w_sum;
  logic              w_unused_carry;
  logic              w_ovf;
  logic              w_lt;
  logic [DATA_W-1:0] w_next;
  logic              w_set;

  logic [DATA_W-1:0] r_result;
  logic              r_set;
  logic              r_zero;

  assign w_op  = opcode_e'(opcode_i);
  assign w_sub = (w_op == OP_SUB) || (w_op == OP_SLT);

  alu_addsub u_addsub (
    .i_a     (rs_i),
    .i_b     (rt_i),
    .i_sub   (w_sub),
    .o_sum   (w_sum),
    .o_carry (w_unused_carry),
    .o_ovf   (w_ovf)
  );

  // Signed less-than is N xor V of A - B; robust across wraparound.
  assign w_lt = w_sum[DATA_W-1] ^ w_ovf;

  always_comb begin
    w_next = '0;
    w_set  = 1'b0;
    unique case (w_op)
      OP_AND: w_next = rs_i & rt_i;
      OP_OR:  w_next = rs_i | rt_i;
      OP_ADD: w_next = w_sum;
      OP_NOT: w_next = ~rs_i;
      OP_SUB: w_next = w_sum;
      OP_SLT: begin
        w_next = {{(DATA_W-1){1'b0}}, w_lt};
        w_set  = w_lt;
      end
      OP_SLL: w_next = {rs_i[DATA_W-2:0], 1'b0};
      OP_XOR: w_next = rs_i ^ rt_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= '0;
      r_set    <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_result <= w_next;
      r_set    <= w_set;
      r_zero   <= (w_next == '0);
    end
  end

  assign alu_result_o = r_result;
  assign set_o        = r_set;
  assign zero         = r_zero;

`ifdef ALU_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf && ((w_op == OP_ADD) || (w_op == OP_SUB));
    end
  end

  assign ovf_o = r_ovf;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases plus random ops
// against an integer-arithmetic reference model.
module tb_alu_core;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rs;
  logic [7:0] rt;
  logic [2:0] op;
  logic [7:0] res;
  logic       set;
  logic       zf;
`ifdef ALU_OVF_EN
  logic       ovf;
`endif

  alu_core dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rs_i         (rs),
    .rt_i         (rt),
    .opcode_i     (op),
    .alu_result_o (res),
    .set_o        (set),
    .zero         (zf)
`ifdef ALU_OVF_EN
    ,
    .ovf_o        (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] e_res;
  logic       e_set;
  logic       e_zero;
  logic       e_ovf;

  function automatic int sgn(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic model(input int o, input int a, input int b);
    int r;
    int s;
    r     = 0;
    s     = 0;
    e_set = 1'b0;
    e_ovf = 1'b0;
    case (o)
      0: r = a & b;
      1: r = a | b;
      2: begin
        r = (a + b) % 256;
        s = sgn(a) + sgn(b);
        e_ovf = (s > 127) || (s < -128);
      end
      3: r = 255 - a;
      4: begin
        r = (a - b + 256) % 256;
        s = sgn(a) - sgn(b);
        e_ovf = (s > 127) || (s < -128);
      end
      5: begin
        r = (sgn(a) < sgn(b)) ? 1 : 0;
        e_set = (r == 1);
      end
      6: r = (a * 2) % 256;
      default: r = a ^ b;
    endcase
    e_res  = 8'(r);
    e_zero = (r == 0);
  endtask

  task automatic chk(input string tag);
    n_vec++;
    assert (res === e_res) else begin
      n_err++;
      $error("FAIL %s result got %h exp %h", tag, res, e_res);
    end
    assert (set === e_set) else begin
      n_err++;
      $error("FAIL %s set got %b exp %b", tag, set, e_set);
    end
    assert (zf === e_zero) else begin
      n_err++;
      $error("FAIL %s zero got %b exp %b", tag, zf, e_zero);
    end
`ifdef ALU_OVF_EN
    assert (ovf === e_ovf) else begin
      n_err++;
      $error("FAIL %s ovf got %b exp %b", tag, ovf, e_ovf);
    end
`endif
  endtask

  task automatic run(input string tag, input int o,
                     input int a, input int b);
    @(negedge clk);
    op = 3'(o);
    rs = 8'(a);
    rt = 8'(b);
    model(o, a, b);
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  task automatic exp_reset();
    e_res  = 8'h00;
    e_set  = 1'b0;
    e_zero = 1'b1;
    e_ovf  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    op    = 3'd1;
    rs    = 8'h5A;
    rt    = 8'h0F;
    #1 rst_n = 1'b0;
    #1 exp_reset();
    chk("reset_init");
    @(posedge clk);
    #1 chk("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    run("and_55_aa", 0, 'h55, 'hAA);
    run("or_0f_f0", 1, 'h0F, 'hF0);
    run("xor_ff_ff", 7, 'hFF, 'hFF);
    run("not_fe", 3, 'hFE, 'h33);
    run("add_05_02", 2, 'h05, 'h02);
    run("sub_fd_fa", 4, 'hFD, 'hFA);
    run("add_ff_01", 2, 'hFF, 'h01);
    run("add_7f_01", 2, 'h7F, 'h01);
    run("sub_80_01", 4, 'h80, 'h01);
    run("slt_01_01", 5, 'h01, 'h01);
    run("slt_ff_01", 5, 'hFF, 'h01);
    run("slt_7f_80", 5, 'h7F, 'h80);
    run("slt_80_7f", 5, 'h80, 'h7F);
    run("sll_ff", 6, 'hFF, 'h00);
    run("sll_80", 6, 'h80, 'hFF);

    for (int i = 0; i < 8; i++)
      run("b2b", i, 'hC3 + i, 'h3C - i);

    run("pre_rst_or", 1, 'h0F, 'hF0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 exp_reset();
    chk("rst_async");
    @(posedge clk);
    #1 chk("rst_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst_sub", 4, 'h10, 'h20);

    for (int i = 0; i < 300; i++)
      run("rand", int'($urandom_range(0, 7)),
          int'($urandom & 32'hFF), int'($urandom & 32'hFF));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
